// File: rtl/pipe_pkg.sv
// Shared constants, state encoding and slot control payload for the MIPS inter-stage registers.
package pipe_pkg;

    localparam logic [31:0]  RESET_PC  = 32'h0000_3000;
    localparam logic [31:0]  NOP_WORD  = 32'h0000_0000;
    localparam int unsigned  DEF_WIDTH = 32;

    localparam int unsigned  F_INSTR = 0;
    localparam int unsigned  F_PC4   = 1;
    localparam int unsigned  F_ALO   = 2;
    localparam int unsigned  F_RTD   = 3;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_e;

    // Per-slot update request; clear outranks load, load outranks drop.
    typedef struct packed {
        logic clear;
        logic load;
        logic drop;
    } slot_ctl_t;

    function automatic logic [1:0] state_count(input stage_state_e st);
        case (st)
            ST_ONE:  return 2'd1;
            ST_FULL: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// One storage entry: a valid flop plus the packed field data.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int unsigned DW = 128
) (
    input  logic          clk,
    input  logic          rst_n,
    input  slot_ctl_t     ctl,
    input  logic [DW-1:0] rst_val,
    input  logic [DW-1:0] d,
    output logic          valid,
    output logic [DW-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            q     <= rst_val;
        end else if (ctl.clear) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (ctl.load) begin
            valid <= 1'b1;
            q     <= d;
        end else if (ctl.drop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register with optional two-entry skid buffer and synchronous bubble flush.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned PC_CH  = F_PC4,
    parameter logic [31:0] PC_RST = RESET_PC,
    parameter int unsigned SKID   = 1
) (
    input  logic                    Preg_clk_i,
    input  logic                    Preg_rst_n_i,
    input  logic                    Preg_flush_i,
    input  logic                    Preg_in_valid_i,
    output logic                    Preg_in_ready_o,
    input  logic [NUM_CH*WIDTH-1:0] Preg_in_data_i,
    output logic                    Preg_out_valid_o,
    input  logic                    Preg_out_ready_i,
    output logic [NUM_CH*WIDTH-1:0] Preg_out_data_o,
    output logic [1:0]              Preg_count_o
);

    localparam int unsigned DW = NUM_CH * WIDTH;

    stage_state_e  state, nxt_state;
    logic          in_ready_q;
    logic [1:0]    count_q;
    slot_ctl_t     m_ctl, s_ctl;
    logic          m_valid, s_valid;
    logic [DW-1:0] m_q, s_q, m_d, rst_img;
    logic          accept, emit;

    // Reset image: all fields zero except the PC+4 field.
    always_comb begin
        rst_img = '0;
        rst_img[PC_CH*WIDTH +: WIDTH] = WIDTH'(PC_RST);
    end

    assign Preg_in_ready_o  = (SKID != 0) ? in_ready_q : (!m_valid || Preg_out_ready_i);
    assign accept           = Preg_in_valid_i && Preg_in_ready_o;
    assign emit             = m_valid && Preg_out_ready_i;
    assign m_d              = s_valid ? s_q : Preg_in_data_i;
    assign Preg_out_valid_o = m_valid;
    assign Preg_out_data_o  = m_q;
    assign Preg_count_o     = count_q;

    // Next state and slot update requests; flush overrides any handshake.
    always_comb begin
        nxt_state = state;
        m_ctl     = '0;
        s_ctl     = '0;
        if (Preg_flush_i) begin
            nxt_state   = ST_EMPTY;
            m_ctl.clear = 1'b1;
            s_ctl.clear = 1'b1;
        end else if (SKID != 0) begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        m_ctl.load = 1'b1;
                        nxt_state  = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && emit) begin
                        m_ctl.load = 1'b1;
                    end else if (accept) begin
                        s_ctl.load = 1'b1;
                        nxt_state  = ST_FULL;
                    end else if (emit) begin
                        m_ctl.drop = 1'b1;
                        nxt_state  = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (emit) begin
                        m_ctl.load = 1'b1;
                        s_ctl.drop = 1'b1;
                        nxt_state  = ST_ONE;
                    end
                end
                default: nxt_state = ST_EMPTY;
            endcase
        end else begin
            if (accept) begin
                m_ctl.load = 1'b1;
                nxt_state  = ST_ONE;
            end else if (emit) begin
                m_ctl.drop = 1'b1;
                nxt_state  = ST_EMPTY;
            end
        end
    end

    always_ff @(posedge Preg_clk_i or negedge Preg_rst_n_i) begin
        if (!Preg_rst_n_i) begin
            state      <= ST_EMPTY;
            in_ready_q <= 1'b1;
            count_q    <= 2'd0;
        end else begin
            state      <= nxt_state;
            in_ready_q <= (nxt_state != ST_FULL);
            count_q    <= state_count(nxt_state);
        end
    end

    pipe_slot #(.DW(DW)) u_main (
        .clk     (Preg_clk_i),
        .rst_n   (Preg_rst_n_i),
        .ctl     (m_ctl),
        .rst_val (rst_img),
        .d       (m_d),
        .valid   (m_valid),
        .q       (m_q)
    );

    pipe_slot #(.DW(DW)) u_skid (
        .clk     (Preg_clk_i),
        .rst_n   (Preg_rst_n_i),
        .ctl     (s_ctl),
        .rst_val (rst_img),
        .d       (Preg_in_data_i),
        .valid   (s_valid),
        .q       (s_q)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: SKID=1 and SKID=0 instances against a queue-level occupancy model.
module tb_pipe_stage_reg;

    localparam int unsigned DW = 128;
    typedef logic [DW-1:0] dw_t;
    localparam dw_t RST_IMG = 128'h0000_0000_0000_0000_0000_3000_0000_0000;

    typedef struct packed {
        logic [1:0] cnt;
        dw_t        e0;
        dw_t        e1;
        dw_t        last;
    } mst_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush, in_valid, out_ready;
    dw_t        in_data;
    logic       r0_ready, r0_valid, r1_ready, r1_valid;
    dw_t        r0_data, r1_data;
    logic [1:0] r0_count, r1_count;

    int n_chk = 0;
    int n_err = 0;
    mst_t mdl [2];

    always #5 clk = ~clk;

    pipe_stage_reg #(.SKID(1)) u0 (
        .Preg_clk_i(clk), .Preg_rst_n_i(rst_n), .Preg_flush_i(flush),
        .Preg_in_valid_i(in_valid), .Preg_in_ready_o(r0_ready), .Preg_in_data_i(in_data),
        .Preg_out_valid_o(r0_valid), .Preg_out_ready_i(out_ready), .Preg_out_data_o(r0_data),
        .Preg_count_o(r0_count)
    );

    pipe_stage_reg #(.SKID(0)) u1 (
        .Preg_clk_i(clk), .Preg_rst_n_i(rst_n), .Preg_flush_i(flush),
        .Preg_in_valid_i(in_valid), .Preg_in_ready_o(r1_ready), .Preg_in_data_i(in_data),
        .Preg_out_valid_o(r1_valid), .Preg_out_ready_i(out_ready), .Preg_out_data_o(r1_data),
        .Preg_count_o(r1_count)
    );

    task automatic chk(input string nm, input dw_t act, input dw_t exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Occupancy model: a FIFO of at most 2 (SKID=1) or 1 (SKID=0) words.
    function automatic mst_t mdl_step(input bit skid, input mst_t s, input logic iv,
                                      input dw_t d, input logic ordy, input logic fl);
        mst_t n = s;
        bit   acc, emt;
        if (fl) begin
            n.cnt  = 2'd0;
            n.last = '0;
        end else begin
            acc = iv && (skid ? (s.cnt < 2'd2) : (s.cnt == 2'd0 || ordy));
            emt = (s.cnt != 2'd0) && ordy;
            if (emt) begin
                n.e0  = n.e1;
                n.cnt = n.cnt - 2'd1;
            end
            if (acc) begin
                if (n.cnt == 2'd0) n.e0 = d;
                else               n.e1 = d;
                n.cnt = n.cnt + 2'd1;
            end
            if (n.cnt != 2'd0) n.last = n.e0;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) mdl[i] <= '{cnt: 2'd0, e0: '0, e1: '0, last: RST_IMG};
        end else begin
            mdl[0] <= mdl_step(1'b1, mdl[0], in_valid, in_data, out_ready, flush);
            mdl[1] <= mdl_step(1'b0, mdl[1], in_valid, in_data, out_ready, flush);
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("u0_valid", dw_t'(r0_valid), dw_t'(mdl[0].cnt != 2'd0));
        chk("u0_data",  r0_data, mdl[0].last);
        chk("u0_count", dw_t'(r0_count), dw_t'(mdl[0].cnt));
        chk("u0_ready", dw_t'(r0_ready), dw_t'(mdl[0].cnt < 2'd2));
        chk("u1_valid", dw_t'(r1_valid), dw_t'(mdl[1].cnt != 2'd0));
        chk("u1_data",  r1_data, mdl[1].last);
        chk("u1_count", dw_t'(r1_count), dw_t'(mdl[1].cnt));
        chk("u1_ready", dw_t'(r1_ready), dw_t'(mdl[1].cnt == 2'd0 || out_ready));
    end

    function automatic dw_t pk(input logic [31:0] w);
        return {w, w ^ 32'h1111_1111, w + 32'h100, ~w};
    endfunction

    task automatic step(input logic v, input dw_t d, input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_u0(input string nm, input logic v, input dw_t d, input int c, input logic rdy);
        chk({nm, "_valid"}, dw_t'(r0_valid), dw_t'(v));
        chk({nm, "_data"},  r0_data, d);
        chk({nm, "_count"}, dw_t'(r0_count), dw_t'(c));
        chk({nm, "_ready"}, dw_t'(r0_ready), dw_t'(rdy));
    endtask

    initial begin
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        #2 rst_n = 1'b0;
        #1;
        chk_u0("reset", 1'b0, RST_IMG, 0, 1'b1);
        chk("reset_u1_data", r1_data, RST_IMG);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 1; k <= 8; k++) begin
            step(1'b1, pk(32'(k)), 1'b1, 1'b0);
            chk_u0("stream", 1'b1, pk(32'(k)), 1, 1'b1);
        end
        step(1'b0, '0, 1'b1, 1'b0);

        step(1'b1, pk(32'hA), 1'b0, 1'b0);
        step(1'b1, pk(32'hB), 1'b0, 1'b0);
        chk_u0("stall", 1'b1, pk(32'hA), 2, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        chk_u0("release", 1'b1, pk(32'hB), 1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);

        step(1'b1, pk(32'hA2), 1'b0, 1'b0);
        step(1'b1, pk(32'hB2), 1'b0, 1'b0);
        chk_u0("full2", 1'b1, pk(32'hA2), 2, 1'b0);
        step(1'b1, pk(32'hC), 1'b1, 1'b1);
        chk_u0("flush", 1'b0, '0, 0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);
        chk_u0("no_c", 1'b0, '0, 0, 1'b1);

        step(1'b1, pk(32'hD), 1'b0, 1'b0);
        in_valid = 1'b1; in_data = pk(32'hE); out_ready = 1'b0;
        #1 chk("s0_ready_low", dw_t'(r1_ready), dw_t'(1'b0));
        out_ready = 1'b1;
        #1 chk("s0_ready_high", dw_t'(r1_ready), dw_t'(1'b1));
        @(posedge clk);
        #1;
        chk("s0_load_valid", dw_t'(r1_valid), dw_t'(1'b1));
        chk("s0_load_data", r1_data, pk(32'hE));

        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, pk(32'hF), 1'b1, 1'b1);
        chk_u0("flush_empty", 1'b0, '0, 0, 1'b1);
        chk("flush_empty_u1", dw_t'(r1_valid), dw_t'(1'b0));

        step(1'b1, pk(32'h60), 1'b0, 1'b0);
        step(1'b1, pk(32'h61), 1'b0, 1'b0);
        chk_u0("full3", 1'b1, pk(32'h60), 2, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_u0("reset_full", 1'b0, RST_IMG, 0, 1'b1);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 99) < 70),
                 {$urandom, $urandom, $urandom, $urandom},
                 1'($urandom_range(0, 99) < 60),
                 1'($urandom_range(0, 99) < 4));
        end
        step(1'b0, '0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
